// File: rtl/ureg_shifter.sv
// ureg_shifter: WIDTH-bit universal register with an autonomous burst serialiser.
//
// Idle modes (MODE): 000 hold, 001 load D, 010 shift left (SI_LSB in),
// 011 shift right (SI_MSB in), 100 rotate left, 101 rotate right,
// 110 hold (reserved), 111 clear.
// START in idle loads D and shifts it out LSB-first on SO_LSB over WIDTH
// enabled cycles, zero-filling from the top; DONE pulses for the first idle cycle.
//
// Ports:
//   CLK     rising-edge clock
//   RST_L   asynchronous active-low reset
//   EN      clock enable; all state (including DONE and the burst counter) holds when low
//   MODE    idle operation select, ignored while BUSY
//   D       parallel load data
//   SI_MSB  serial input for shift right
//   SI_LSB  serial input for shift left
//   START   burst request, sampled only in idle with EN high
//   Q, Q_L  register contents and its complement
//   SO_MSB  Q[WIDTH-1]
//   SO_LSB  Q[0], burst serial output
//   BUSY    burst in progress
//   DONE    one-cycle end-of-burst pulse

module ureg_shifter #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI_MSB,
    input  logic             SI_LSB,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_L,
    output logic             SO_MSB,
    output logic             SO_LSB,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (busy_q) begin
            q_d   = {1'b0, q_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
            // Last bit leaves on this edge; DONE marks the first idle cycle.
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (START) begin
            q_d    = D;
            cnt_d  = CW'(WIDTH);
            busy_d = 1'b1;
        end else begin
            case (MODE)
                3'b001:  q_d = D;
                3'b010:  q_d = {q_q[WIDTH-2:0], SI_LSB};
                3'b011:  q_d = {SI_MSB, q_q[WIDTH-1:1]};
                3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                3'b101:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                3'b111:  q_d = '0;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (EN) begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign Q      = q_q;
    assign Q_L    = ~q_q;
    assign SO_MSB = q_q[WIDTH-1];
    assign SO_LSB = q_q[0];
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: doc/ureg_shifter.md
Name: ureg_shifter

Overview:
- Parametrised universal register: generalises the single-bit D flip-flop to a WIDTH-bit register with hold, parallel load, shift, rotate and clear modes.
- Adds an autonomous burst serialiser: loads a word and shifts it out LSB-first over WIDTH cycles with BUSY/DONE handshake.
- Used as the storage/serial-conversion primitive in the lab datapaths.
- Outputs are complementary (Q, Q_L), as on the existing flip-flop.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 to 32.
- RESET_VAL, 0, value Q takes on reset.

Ports:
- CLK  input  1  rising-edge clock.
- RST_L  input  1  asynchronous reset, active-low.
- EN  input  1  clock enable; when low, all state holds, including the burst counter.
- MODE  input  3  operation select; ignored while BUSY=1.
- D  input  WIDTH  parallel load data.
- SI_MSB  input  1  serial input entering at bit WIDTH-1 on a shift-right.
- SI_LSB  input  1  serial input entering at bit 0 on a shift-left.
- START  input  1  burst request; sampled only when BUSY=0 and EN=1.
- Q  output  WIDTH  register contents.
- Q_L  output  WIDTH  always equal to ~Q, purely combinational.
- SO_MSB  output  1  equal to Q[WIDTH-1].
- SO_LSB  output  1  equal to Q[0]; this is the burst serial output.
- BUSY  output  1  burst in progress.
- DONE  output  1  one-cycle pulse at the end of a burst.

Behaviour:
- Reset (RST_L=0, async, takes effect immediately):
  - Q=RESET_VAL, Q_L=~RESET_VAL.
  - BUSY=0, DONE=0, burst counter CNT=0.
  - Asserting reset mid-burst aborts the burst and does not produce a DONE pulse.
- All state updates occur on the rising edge of CLK, only when EN=1. With EN=0, DONE is held as well.
- IDLE state (BUSY=0), MODE encoding:
  - 000: hold.
  - 001: Q<=D.
  - 010: shift left, Q<={Q[W-2:0],SI_LSB}.
  - 011: shift right, Q<={SI_MSB,Q[W-1:1]}.
  - 100: rotate left, Q<={Q[W-2:0],Q[W-1]}.
  - 101: rotate right, Q<={Q[0],Q[W-1:1]}.
  - 110: reserved; behaves as hold.
  - 111: Q<=0.
- START=1 in IDLE with EN=1:
  - Overrides MODE.
  - Q<=D, BUSY<=1, CNT<=WIDTH.
- BUSY state, on each enabled edge:
  - Q<={1'b0,Q[W-1:1]} (zero fill); CNT<=CNT-1.
  - When CNT==1: BUSY<=0, DONE<=1.
- Burst timing:
  - BUSY is high for exactly WIDTH enabled cycles.
  - In the k-th BUSY cycle (k=1..WIDTH), SO_LSB=D[k-1].
  - After the burst, Q=0.
- DONE:
  - Registered; high for exactly one enabled cycle, which is the first cycle with BUSY=0.
  - Clears on the next enabled edge.
- START while BUSY=1 is ignored; it is not queued.
- START on the same edge DONE rises (first IDLE cycle): accepted; a new burst begins, and DONE still pulses for that one cycle.
- CNT width is clog2(WIDTH+1). There is no wrap-around, because CNT only decrements from WIDTH to 0.
- Latency:
  - Mode ops: Q updates one edge after sampling.
  - Burst: first bit appears on SO_LSB one edge after START.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, pulse RST_L low between edges -> Q=A5 and Q_L=5A immediately; BUSY=0, DONE=0.
- Load/shift/rotate: MODE=001 with D=8'h81, then MODE=010 with SI_LSB=1 -> Q=03; then MODE=101 -> Q=81; then MODE=011 with SI_MSB=0 -> Q=40; then MODE=111 -> Q=00.
- Burst:
  - Stimulus: START with D=8'hB4, EN=1.
  - SO_LSB over the 8 BUSY cycles = 0,0,1,0,1,1,0,1.
  - BUSY is high for 8 cycles.
  - DONE is high for exactly 1 cycle after that, with Q=00.
- Enable stall: insert EN=0 for 3 cycles mid-burst -> Q, CNT, BUSY and SO_LSB are frozen; total BUSY cycles = 8 + 3; bit sequence unchanged.
- Collisions:
  - START and MODE=001 together in IDLE -> burst wins.
  - START while BUSY is ignored.
  - START in the DONE cycle starts a new burst of 8.
- Reset mid-burst: RST_L low at the 4th BUSY cycle -> BUSY=0, Q=RESET_VAL, and no DONE pulse follows.
